// File: rtl/y_arith_pkg.sv
// Shared definitions for the serial arithmetic units: FSM encoding and chunk sizing helpers.
package y_arith_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index counter width; a single-chunk unit still gets a 1-bit counter.
  function automatic int calc_idxw(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/y_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from per-bit full-adder cells.
module y_adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CHUNK];
  // Carry into the top bit, needed for signed overflow detection.
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/y_adder_serial.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LS chunk first, start/done handshake.
module y_adder_serial
  import y_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IW     = calc_idxw(WIDTH, CHUNK);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
  logic             cr;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] csum;
  logic             cco, cmsb;
  logic             accept, last;

  assign busy   = (state == S_RUN);
  assign accept = (state == S_IDLE) && start;
  assign last   = (idx == IW'(NCHUNK - 1));

  // Operands shift right each step, so the adder always sees the low chunk.
  y_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (opa[CHUNK-1:0]),
    .b     (opb[CHUNK-1:0]),
    .cin   (cr),
    .sum   (csum),
    .cout  (cco),
    .c_msb (cmsb)
  );

  // New chunk enters at the top; after NCHUNK steps the LS chunk has reached bit 0.
  always_comb begin
    acc_nxt = (acc >> CHUNK) | (WIDTH'(csum) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa  <= '0;
      opb  <= '0;
      acc  <= '0;
      cr   <= 1'b0;
      idx  <= '0;
      done <= 1'b0;
      z    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Subtract as a + ~b + !cin by inverting b and cin once at latch time.
        opa <= a;
        opb <= b ^ {WIDTH{sub}};
        cr  <= cin ^ sub;
        idx <= '0;
      end else if (state == S_RUN) begin
        opa <= opa >> CHUNK;
        opb <= opb >> CHUNK;
        cr  <= cco;
        acc <= acc_nxt;
        idx <= idx + 1'b1;
        if (last) begin
          z    <= acc_nxt;
          cout <= cco;
          ovf  <= cco ^ cmsb;
          zero <= (acc_nxt == '0);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_y_adder_serial.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop them on done.
module tb_y_adder_serial;

  typedef struct {
    logic [31:0] z;
    logic        c;
    logic        o;
    logic        zr;
    int          due;
  } exp_t;

  logic        clk, rst;
  logic        start1, cin1, sub1, busy1, done1, cout1, ovf1, zero1;
  logic [31:0] a1, b1, z1;
  logic        start2, cin2, sub2, busy2, done2, cout2, ovf2, zero2;
  logic [15:0] a2, b2, z2;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q1[$];
  exp_t q2[$];

  y_adder_serial #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .z(z1), .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  y_adder_serial #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .z(z2), .cout(cout2), .ovf(ovf2), .zero(zero2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) chk("d1 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("d1 z", z1, e.z);
        chk("d1 cout", {31'd0, cout1}, {31'd0, e.c});
        chk("d1 ovf", {31'd0, ovf1}, {31'd0, e.o});
        chk("d1 zero", {31'd0, zero1}, {31'd0, e.zr});
        chk("d1 latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) chk("d2 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2 z", {16'd0, z2}, e.z);
        chk("d2 cout", {31'd0, cout2}, {31'd0, e.c});
        chk("d2 ovf", {31'd0, ovf2}, {31'd0, e.o});
        chk("d2 zero", {31'd0, zero2}, {31'd0, e.zr});
        chk("d2 latency", cyc, e.due);
      end
    end
  end

  // Called at a negedge; drives start through the next posedge.
  task automatic issue1(input logic [31:0] ia, ib, input logic ic, is,
                        input logic [31:0] ez, input logic ec, eo, ezr);
    a1 = ia; b1 = ib; cin1 = ic; sub1 = is; start1 = 1'b1;
    @(posedge clk); #1;
    q1.push_back('{ez, ec, eo, ezr, cyc + 4});
    start1 = 1'b0;
    a1 = ~ia; b1 = ~ib; cin1 = ~ic; sub1 = ~is;
  endtask

  task automatic issue2(input logic [15:0] ia, ib, input logic ic, is,
                        input logic [31:0] ez, input logic ec, eo, ezr);
    a2 = ia; b2 = ib; cin2 = ic; sub2 = is; start2 = 1'b1;
    @(posedge clk); #1;
    q2.push_back('{ez, ec, eo, ezr, cyc + 1});
    start2 = 1'b0;
    a2 = ~ia; b2 = ~ib;
  endtask

  task automatic wait_done1();
    int n = 0;
    while (!done1 && n < 30) begin @(negedge clk); n++; end
    if (!done1) chk("d1 done timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle1();
    int n = 0;
    @(negedge clk);
    while (busy1 && n < 30) begin @(negedge clk); n++; end
    if (busy1) chk("d1 idle timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle2();
    int n = 0;
    @(negedge clk);
    while (busy2 && n < 30) begin @(negedge clk); n++; end
    if (busy2) chk("d2 idle timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0;
    #1;
    chk("reset busy", {31'd0, busy1}, 32'd0);
    chk("reset done", {31'd0, done1}, 32'd0);
    chk("reset z", z1, 32'd0);
    chk("reset flags", {29'd0, cout1, ovf1, zero1}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Carry ripples through every chunk
    issue1(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1); wait_idle1();
    issue1(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0); wait_idle1();
    issue1(32'h12345678, 32'h9ABCDEF0, 1, 0, 32'hACF13569, 0, 0, 0); wait_idle1();
    issue1(32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0); wait_idle1();
    issue1(32'h00000010, 32'h00000005, 1, 1, 32'h0000000A, 1, 0, 0); wait_idle1();
    issue1(32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0, 0); wait_idle1();
    issue1(32'h00000007, 32'h00000005, 0, 1, 32'h00000002, 1, 0, 0); wait_idle1();

    // Async reset two cycles into an operation
    issue1(32'hAAAAAAAA, 32'h11111111, 0, 0, 32'hBBBBBBBB, 0, 0, 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy1}, 32'd0);
    chk("abort z", z1, 32'd0);
    chk("abort flags", {29'd0, cout1, ovf1, zero1}, 32'd0);
    q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin @(negedge clk); if (done1) nd++; end
    chk("no done after abort", nd, 32'd0);
    issue1(32'h11111111, 32'h22222222, 0, 0, 32'h33333333, 0, 0, 0); wait_idle1();

    // Start while busy is ignored; start in the done cycle is accepted
    issue1(32'h00000001, 32'h00000002, 0, 0, 32'h00000003, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    a1 = 32'hFFFF0000; b1 = 32'h0000FFFF; cin1 = 1; sub1 = 1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    wait_done1();
    chk("done seen", {31'd0, done1}, 32'd1);
    issue1(32'h00FF00FF, 32'hFF00FF01, 0, 0, 32'h00000000, 1, 0, 1);
    chk("busy after done-cycle start", {31'd0, busy1}, 32'd1);
    chk("z held mid-op", z1, 32'h00000003);
    wait_idle1();

    // Single-chunk instance
    @(negedge clk);
    issue2(16'h8000, 16'h8000, 0, 0, 32'h0000, 1, 1, 1); wait_idle2();
    issue2(16'h1234, 16'h0001, 1, 0, 32'h1236, 0, 0, 0); wait_idle2();
    issue2(16'h0003, 16'h0005, 0, 1, 32'hFFFE, 0, 0, 0); wait_idle2();

    repeat (6) @(negedge clk);
    chk("d1 queue drained", q1.size(), 32'd0);
    chk("d2 queue drained", q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
